// File: rtl/circular_fifo_pkg.sv
// DataTypes: shared byte/flag types and default depth for the circular FIFO
package DataTypes;
  typedef logic bit_t;
  typedef logic [7:0] fifo_in;
  typedef logic [7:0] fifo_out;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/circular_fifo.sv
// circular_fifo: single-clock byte FIFO with wrapping pointers and occupancy count
module circular_fifo
  import DataTypes::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset,
  input  fifo_in  datainput,
  input  bit_t    push,
  input  bit_t    pop,
  output fifo_out dataoutput,
  output bit_t    full,
  output bit_t    empty
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic push_ok, pop_ok;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    pop_ok = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end
  // storage write; contents are not cleared by reset
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= datainput;
  // pointers, count and registered read data; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dataoutput <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dataoutput <= mem[rd_ptr];
      end
      count <= (push_ok && !pop_ok) ? count + 1'b1 : (pop_ok && !push_ok) ? count - 1'b1 : count;
    end
endmodule

// File: tb/tb_circular_fifo.sv
// tb_circular_fifo: directed scoreboard bench for circular_fifo
module tb_circular_fifo;
  logic clk = 0, reset = 0, push = 0, pop = 0;
  logic [7:0] datainput = 0, dataoutput;
  logic full, empty;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q [$];

  circular_fifo dut (
    .clk(clk), .reset(reset), .datainput(datainput), .push(push), .pop(pop),
    .dataoutput(dataoutput), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: each cycle with a pending read expectation compares dataoutput
  always @(negedge clk)
    if (exp_q.size() > 0) chk("dataoutput", dataoutput, exp_q.pop_front());

  task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                     input logic has_exp, input logic [7:0] e);
    @(negedge clk);
    push = p; pop = q; datainput = d;
    @(posedge clk);
    #1;
    push = 0; pop = 0;
    if (has_exp) exp_q.push_back(e);
  endtask

  task automatic flags(input string name, input logic e_full, input logic e_empty);
    chk({name, "_full"}, {7'b0, full}, {7'b0, e_full});
    chk({name, "_empty"}, {7'b0, empty}, {7'b0, e_empty});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1;
    repeat (n) @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] v1 [4];
  initial begin
    v1 = '{8'h45, 8'h90, 8'hF4, 8'hEE};
    do_reset(2);
    flags("reset", 0, 1);
    chk("reset_dout", dataoutput, 8'h00);
    // single push/pop order
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, v1[i], 0, 0);
      flags("push1", 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, v1[i]);
    @(negedge clk);
    flags("pop3", 0, 0);
    cyc(0, 1, 0, 1, 8'hEE);
    flags("drain1", 0, 1);
    // fill and overflow
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
    flags("fill8", 1, 0);
    cyc(1, 0, 8'hFF, 0, 0);
    flags("overflow", 1, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 1, 8'(i));
    flags("drain8", 0, 1);
    cyc(0, 1, 0, 1, 8'h08);
    flags("underflow", 0, 1);
    // wrap-around
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'hA0 + 8'(i), 0, 0);
    flags("wrap_full", 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 8'hA0 + 8'(i));
    flags("wrap_empty", 0, 1);
    // simultaneous push/pop when full
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h20 + 8'(i), 0, 0);
    cyc(1, 1, 8'h30, 1, 8'h20);
    flags("pp_full", 1, 0);
    for (int i = 1; i < 8; i++) cyc(0, 1, 0, 1, 8'h20 + 8'(i));
    cyc(0, 1, 0, 1, 8'h30);
    flags("pp_drain", 0, 1);
    // simultaneous push/pop when empty: only push taken, output holds
    cyc(1, 1, 8'h55, 1, 8'h30);
    flags("pp_empty", 0, 0);
    cyc(0, 1, 0, 1, 8'h55);
    flags("pp_empty_pop", 0, 1);
    // mid-operation reset
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h61 + 8'(i), 0, 0);
    flags("pre_reset", 0, 0);
    do_reset(1);
    flags("mid_reset", 0, 1);
    chk("mid_reset_dout", dataoutput, 8'h00);
    cyc(0, 1, 0, 1, 8'h00);
    flags("post_reset_pop", 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
